e_stage_mdu: RTL and testbench



---
 rtl/e_stage_mdu.sv | 153 +++++++++++++++
 tb/tb_e_stage_mdu.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/e_stage_mdu.sv
`default_nettype none
// ============================================================================
// Module   : e_stage_mdu
// Brief    : Execute-stage multiply/divide unit owning HI/LO, with multi-cycle
//            busy/stall. Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
// Revision : 1.0 - initial release
// ============================================================================
module e_stage_mdu #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        cancel,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MTHI  = 4'd5;
  localparam logic [3:0] c_OP_MTLO  = 4'd6;
  localparam logic [3:0] c_OP_MADD  = 4'd7;
  localparam logic [3:0] c_OP_MADDU = 4'd8;
  localparam logic [3:0] c_OP_MSUB  = 4'd9;
  localparam logic [3:0] c_OP_MSUBU = 4'd10;
  localparam logic [4:0] c_MUL_CNT  = 5'(MUL_CYCLES);
  localparam logic [4:0] c_DIV_CNT  = 5'(DIV_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [4:0]  r_count;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_pend;

  logic        w_accept;
  logic        w_isMul;
  logic        w_isDiv;
  logic        w_isMulti;
  logic [63:0] w_prodS;
  logic [63:0] w_prodU;
  logic [63:0] w_result;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [31:0] w_qMag;
  logic [31:0] w_rMag;
  logic [31:0] w_qU;
  logic [31:0] w_rU;
  logic        w_divByZero;

  always_comb begin
    w_isMul = (op == c_OP_MULT) || (op == c_OP_MULTU);
`ifdef MDU_MADD_EN
    w_isMul = w_isMul || ((op >= c_OP_MADD) && (op <= c_OP_MSUBU));
`endif
    w_isDiv   = (op == c_OP_DIV) || (op == c_OP_DIVU);
    w_isMulti = w_isMul || w_isDiv;
    w_accept  = (r_state == S_IDLE) && start && !cancel;
  end

  // Sign-extended 64-bit operands make the low 64 bits equal the signed product.
  assign w_prodS = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prodU = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes so MIN_INT / -1 wraps to MIN_INT, remainder 0.
  assign w_divByZero = (b == 32'd0);
  assign w_absA = a[31] ? (32'd0 - a) : a;
  assign w_absB = w_divByZero ? 32'd1 : (b[31] ? (32'd0 - b) : b);
  assign w_qMag = w_absA / w_absB;
  assign w_rMag = w_absA % w_absB;
  assign w_qU   = a / (w_divByZero ? 32'd1 : b);
  assign w_rU   = a % (w_divByZero ? 32'd1 : b);

  always_comb begin
    w_result = {r_hi, r_lo};
    case (op)
      c_OP_MULT:  w_result = w_prodS;
      c_OP_MULTU: w_result = w_prodU;
      c_OP_DIV: begin
        if (!w_divByZero) begin
          w_result[31:0]  = (a[31] ^ b[31]) ? (32'd0 - w_qMag) : w_qMag;
          w_result[63:32] = a[31] ? (32'd0 - w_rMag) : w_rMag;
        end
      end
      c_OP_DIVU: begin
        if (!w_divByZero) w_result = {w_rU, w_qU};
      end
`ifdef MDU_MADD_EN
      c_OP_MADD:  w_result = {r_hi, r_lo} + w_prodS;
      c_OP_MADDU: w_result = {r_hi, r_lo} + w_prodU;
      c_OP_MSUB:  w_result = {r_hi, r_lo} - w_prodS;
      c_OP_MSUBU: w_result = {r_hi, r_lo} - w_prodU;
`endif
      default:    w_result = {r_hi, r_lo};
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_isMulti) w_stateNext = S_RUN;
      S_RUN:   if (r_count == 5'd1) w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= 5'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_pend  <= 64'd0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        if (op == c_OP_MTHI) r_hi <= a;
        if (op == c_OP_MTLO) r_lo <= a;
        if (w_isMulti) begin
          r_pend  <= w_result;
          r_count <= w_isDiv ? c_DIV_CNT : c_MUL_CNT;
        end
      end
    end else begin
      r_count <= r_count - 5'd1;
      if (r_count == 5'd1) {r_hi, r_lo} <= r_pend;
    end
  end

  assign busy      = (r_state == S_RUN);
  assign stall_req = busy || (start && !cancel && w_isMulti);
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_e_stage_mdu.sv
`default_nettype none
// Self-checking bench for e_stage_mdu: transaction-level HI/LO model compared every
// cycle, directed literal cases, then randomized op/operand/cancel traffic.
module tb_e_stage_mdu;
  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  bit checkOn = 1'b0;

  e_stage_mdu #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clock(clock), .reset(reset), .start(start), .cancel(cancel), .op(op),
    .a(a), .b(b), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit isMulti(input logic [3:0] o);
`ifdef MDU_MADD_EN
    return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd7 && o <= 4'd10);
`else
    return (o >= 4'd1 && o <= 4'd4);
`endif
  endfunction

  // Architectural result of an op as {hi,lo}, using 64-bit integer arithmetic.
  function automatic logic [63:0] expect64(input logic [3:0] o, input logic [31:0] x,
                                           input logic [31:0] y, input logic [63:0] acc);
    longint sx, sy, sp;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = 64'(x);
    uy = 64'(y);
    sp = sx * sy;
    up = ux * uy;
    case (o)
      4'd1: return 64'(sp);
      4'd2: return 64'(up);
      4'd3: return (y == 32'd0) ? acc : {32'(sx % sy), 32'(sx / sy)};
      4'd4: return (y == 32'd0) ? acc : {32'(ux % uy), 32'(ux / uy)};
`ifdef MDU_MADD_EN
      4'd7:  return acc + 64'(sp);
      4'd8:  return acc + 64'(up);
      4'd9:  return acc - 64'(sp);
      4'd10: return acc - 64'(up);
`endif
      default: return acc;
    endcase
  endfunction

  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;
  logic [63:0] mPend = 64'd0;
  int          mLeft = 0;

  always @(posedge clock) begin
    if (reset) begin
      mHi <= 32'd0;
      mLo <= 32'd0;
      mLeft <= 0;
    end else if (mLeft > 0) begin
      mLeft <= mLeft - 1;
      if (mLeft == 1) {mHi, mLo} <= mPend;
    end else if (start && !cancel) begin
      if (op == 4'd5) mHi <= a;
      else if (op == 4'd6) mLo <= a;
      else if (isMulti(op)) begin
        mPend <= expect64(op, a, b, {mHi, mLo});
        mLeft <= (op == 4'd3 || op == 4'd4) ? DIV_CYCLES : MUL_CYCLES;
      end
    end
  end

  always @(negedge clock) begin
    if (checkOn) begin
      chk("cyc_busy", 64'(busy), 64'(mLeft > 0));
      chk("cyc_stall_req", 64'(stall_req), 64'((mLeft > 0) || (start && !cancel && isMulti(op))));
      chk("cyc_hi", 64'(hi), 64'(mHi));
      chk("cyc_lo", 64'(lo), 64'(mLo));
    end
  end

  task automatic waitIdle(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!busy) break;
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL busy_bound: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic runOp(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic c, output int nBusy, output logic stallIssue);
    @(posedge clock); #1;
    start = 1'b1; cancel = c; op = o; a = x; b = y;
    @(negedge clock);
    stallIssue = stall_req;
    @(posedge clock); #1;
    start = 1'b0; cancel = 1'b0; op = 4'd0;
    waitIdle(nBusy);
  endtask

  int n;
  logic s;
  logic [31:0] ra, rb;

  initial begin
    repeat (2) @(posedge clock);
    checkOn = 1'b1;
    @(negedge clock);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    runOp(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, n, s);
    chk("mult_busy_cycles", 64'(n), 64'd5);
    chk("mult_stall_issue", 64'(s), 64'd1);
    chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo), 64'hFFFFFFFA);

    runOp(4'd4, 32'd100, 32'd7, 1'b0, n, s);
    chk("divu_busy_cycles", 64'(n), 64'd10);
    chk("divu_hi", 64'(hi), 64'd2);
    chk("divu_lo", 64'(lo), 64'd14);

    runOp(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, n, s);
    chk("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_neg_hi", 64'(hi), 64'hFFFFFFFF);

    runOp(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, n, s);
    chk("div_ovf_lo", 64'(lo), 64'h80000000);
    chk("div_ovf_hi", 64'(hi), 64'd0);

    runOp(4'd5, 32'h11, 32'd0, 1'b0, n, s);
    chk("mthi_stall", 64'(s), 64'd0);
    chk("mthi_busy", 64'(n), 64'd0);
    runOp(4'd6, 32'h22, 32'd0, 1'b0, n, s);
    runOp(4'd4, 32'd1234, 32'd0, 1'b0, n, s);
    chk("div0_busy_cycles", 64'(n), 64'd10);
    chk("div0_hi", 64'(hi), 64'h11);
    chk("div0_lo", 64'(lo), 64'h22);

    runOp(4'd1, 32'd6, 32'd7, 1'b1, n, s);
    chk("cancel_busy", 64'(n), 64'd0);
    chk("cancel_stall", 64'(s), 64'd0);
    chk("cancel_hi", 64'(hi), 64'h11);
    chk("cancel_lo", 64'(lo), 64'h22);

    // cancel while running must not stop the commit
    @(posedge clock); #1;
    start = 1'b1; op = 4'd1; a = 32'd6; b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0; cancel = 1'b1;
    repeat (2) @(posedge clock); #1;
    cancel = 1'b0;
    waitIdle(n);
    chk("midcancel_lo", 64'(lo), 64'd42);
    chk("midcancel_hi", 64'(hi), 64'd0);

    // MTLO offered during RUN is ignored
    @(posedge clock); #1;
    start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4;
    @(posedge clock); #1;
    op = 4'd6; a = 32'd5;
    repeat (2) @(posedge clock); #1;
    start = 1'b0; op = 4'd0;
    waitIdle(n);
    chk("ignored_lo", 64'(lo), 64'd12);
    chk("ignored_hi", 64'(hi), 64'd0);

    // reset in the third busy cycle aborts without commit
    @(posedge clock); #1;
    start = 1'b1; op = 4'd1; a = 32'hFFFFFFFF; b = 32'd2;
    @(posedge clock); #1;
    start = 1'b0; op = 4'd0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

`ifdef MDU_MADD_EN
    runOp(4'd6, 32'd10, 32'd0, 1'b0, n, s);
    runOp(4'd8, 32'd2, 32'd3, 1'b0, n, s);
    chk("maddu_busy_cycles", 64'(n), 64'd5);
    chk("maddu_lo", 64'(lo), 64'd16);
    chk("maddu_hi", 64'(hi), 64'd0);
    runOp(4'd9, 32'd1, 32'd17, 1'b0, n, s);
    chk("msub_hilo", {32'(hi), 32'(lo)}, 64'hFFFFFFFF_FFFFFFFF);
`else
    runOp(4'd5, 32'h33, 32'd0, 1'b0, n, s);
    runOp(4'd7, 32'd2, 32'd3, 1'b0, n, s);
    chk("op7_busy", 64'(n), 64'd0);
    chk("op7_stall", 64'(s), 64'd0);
    chk("op7_hi", 64'(hi), 64'h33);
    chk("op7_lo", 64'(lo), 64'd0);
`endif

    for (int i = 0; i < 250; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 9);
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: rb = -$urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      runOp(4'($urandom_range(0, 15)), ra, rb, ($urandom_range(0, 7) == 0), n, s);
    end

    checkOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
